// File: rtl/fp_seq_pkg.sv
// Shared types and constants for the sequential floating-point log2 datapath.
package fp_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        ITER,
        NORM,
        DONE
    } state_t;

    localparam int ST_INVALID = 3;
    localparam int ST_INF     = 2;
    localparam int ST_ZERO    = 1;
    localparam int ST_INEXACT = 0;

    function automatic int bias_of(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    function automatic int frac_bits_of(input int sw, input int ep);
        return sw + ep + 2;
    endfunction

    function automatic int n_iter_of(input int fb, input int ipc);
        return (fb + ipc - 1) / ipc;
    endfunction

    function automatic logic [63:0] qnan_of(input int sw, input int ew);
        return (((64'd1 << ew) - 64'd1) << sw) | (64'd1 << (sw - 1));
    endfunction

    function automatic logic [63:0] inf_of(input int sw, input int ew,
                                           input logic neg);
        logic [63:0] v;
        v = ((64'd1 << ew) - 64'd1) << sw;
        if (neg) v = v | (64'd1 << (sw + ew));
        return v;
    endfunction

    function automatic logic [63:0] zero_of(input int sw, input int ew);
        return 64'(sw - sw) + 64'(ew - ew);
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; returns W when the input is all zeros.
module fp_lzc #(
    parameter int W = 34,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  d,
    output logic [CW-1:0] cnt
);

    // Highest set bit wins because it is visited last.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (d[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_log2_seq.sv
// Sequential secret-shared float log2 by iterative mantissa squaring.
// Define FP_LOG2_SEQ_STATUS_EN to add the status[3:0] output.
module fp_log2_seq
    import fp_seq_pkg::*;
#(
    parameter int SIG_WIDTH      = 23,
    parameter int EXP_WIDTH      = 8,
    parameter int EXTRA_PREC     = 0,
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]   g_input,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]   e_input,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [SIG_WIDTH+EXP_WIDTH:0]   o,
    output logic                           out_valid,
    input  logic                           out_ready
`ifdef FP_LOG2_SEQ_STATUS_EN
    ,
    output logic [3:0]                     status
`endif
);

    localparam int W    = SIG_WIDTH + EXP_WIDTH + 1;
    localparam int BIAS = bias_of(EXP_WIDTH);
    localparam int FB   = frac_bits_of(SIG_WIDTH, EXTRA_PREC);
    localparam int K    = ITER_PER_CYCLE;
    localparam int NI   = n_iter_of(FB, K);
    localparam int XW   = FB + 1;
    localparam int FW   = NI * K;
    localparam int EW1  = EXP_WIDTH + 1;
    localparam int LW   = EW1 + FB;
    localparam int CW   = $clog2(LW + 1);
    localparam int NW   = $clog2(NI + 1);

    localparam logic [63:0] NAN64  = qnan_of(SIG_WIDTH, EXP_WIDTH);
    localparam logic [63:0] PINF64 = inf_of(SIG_WIDTH, EXP_WIDTH, 1'b0);
    localparam logic [63:0] NINF64 = inf_of(SIG_WIDTH, EXP_WIDTH, 1'b1);
    localparam logic [W-1:0] C_NAN  = NAN64[W-1:0];
    localparam logic [W-1:0] C_PINF = PINF64[W-1:0];
    localparam logic [W-1:0] C_NINF = NINF64[W-1:0];

    state_t state_q, state_d;

    logic [W-1:0]   num_q;
    logic [W-1:0]   o_q;
    logic [W-1:0]   spec_o_q;
    logic           spec_q;
    logic [EW1-1:0] e_q;
    logic [XW-1:0]  x_q;
    logic [FW-1:0]  f_q;
    logic [NW-1:0]  cnt_q;

    logic                 sgn;
    logic [EXP_WIDTH-1:0] ex;
    logic [SIG_WIDTH-1:0] mt;
    logic                 spec_d;
    logic [W-1:0]         spec_o_d;

    assign {sgn, ex, mt} = num_q;

    // Early-exit operands; -0 and negative denormals flush to -inf.
    always_comb begin
        spec_d   = 1'b1;
        spec_o_d = C_NAN;
        if (ex == '0) begin
            spec_o_d = C_NINF;
        end else if (sgn) begin
            spec_o_d = C_NAN;
        end else if ((&ex) && (|mt)) begin
            spec_o_d = C_NAN;
        end else if (&ex) begin
            spec_o_d = C_PINF;
        end else begin
            spec_d = 1'b0;
        end
    end

    logic [XW-1:0] x_ch [K+1];
    logic [K-1:0]  bit_c;
    logic [K-1:0]  lost_c;

    assign x_ch[0] = x_q;

    for (genvar k = 0; k < K; k++) begin : g_sq
        logic [2*XW-1:0] prod;
        logic [FB+1:0]   tr;
        assign prod = {{XW{1'b0}}, x_ch[k]} * {{XW{1'b0}}, x_ch[k]};
        assign tr = prod[2*XW-1 -: FB+2];
        assign bit_c[K-1-k] = tr[FB+1];
        assign x_ch[k+1] = tr[FB+1] ? tr[FB+1:1] : tr[FB:0];
        assign lost_c[k] = (|prod[2*XW-FB-3:0]) | (tr[FB+1] & tr[0]);
    end

    logic [LW-1:0]        l_val;
    logic [LW-1:0]        mag;
    logic [LW-1:0]        nrm;
    logic                 neg;
    logic [CW-1:0]        lz;
    logic [SIG_WIDTH-1:0] mant_n;
    logic                 guard;
    logic                 sticky;
    logic                 rnd;
    logic [SIG_WIDTH:0]   mant_r;
    logic [EXP_WIDTH-1:0] exp_n;
    logic [W-1:0]         res;

    assign l_val = {e_q, f_q[FW-1 -: FB]};
    assign neg   = l_val[LW-1];
    assign mag   = neg ? (~l_val + LW'(1)) : l_val;

    fp_lzc #(.W(LW)) u_lzc (
        .d   (mag),
        .cnt (lz)
    );

    // nrm MSB is the leading one; clear only when L is exactly zero.
    assign nrm    = mag << lz;
    assign mant_n = nrm[LW-2 -: SIG_WIDTH];
    assign guard  = nrm[LW-2-SIG_WIDTH];
    assign sticky = |nrm[LW-3-SIG_WIDTH:0];
    assign rnd    = guard & (sticky | mant_n[0]);
    assign mant_r = {1'b0, mant_n} + (SIG_WIDTH+1)'(rnd);
    assign exp_n  = EXP_WIDTH'(BIAS + EXP_WIDTH) - EXP_WIDTH'(lz)
                  + EXP_WIDTH'(mant_r[SIG_WIDTH]);
    assign res    = nrm[LW-1] ? {neg, exp_n, mant_r[SIG_WIDTH-1:0]} : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = DECODE;
            DECODE:  state_d = spec_d ? NORM : ITER;
            ITER:    if (cnt_q == NW'(NI - 1)) state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        o         = o_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_q    <= '0;
            o_q      <= '0;
            spec_o_q <= '0;
            spec_q   <= 1'b0;
            e_q      <= '0;
            x_q      <= '0;
            f_q      <= '0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) num_q <= g_input ^ e_input;
                end
                DECODE: begin
                    spec_q   <= spec_d;
                    spec_o_q <= spec_o_d;
                    e_q      <= {1'b0, ex} - EW1'(BIAS);
                    x_q      <= {1'b1, mt, {(FB-SIG_WIDTH){1'b0}}};
                    f_q      <= '0;
                    cnt_q    <= '0;
                end
                ITER: begin
                    x_q   <= x_ch[K];
                    f_q   <= {f_q[FW-K-1:0], bit_c};
                    cnt_q <= cnt_q + NW'(1);
                end
                NORM: begin
                    o_q <= spec_q ? spec_o_q : res;
                end
                default: ;
            endcase
        end
    end

`ifdef FP_LOG2_SEQ_STATUS_EN
    localparam logic [FW-1:0] SURP_MASK = ~({FW{1'b1}} << (FW - FB));

    logic [3:0] spec_st_d;
    logic [3:0] spec_st_q;
    logic [3:0] st_q;
    logic       lost_q;

    always_comb begin
        spec_st_d = '0;
        if (spec_o_d == C_NAN) spec_st_d[ST_INVALID] = 1'b1;
        else                   spec_st_d[ST_INF]     = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spec_st_q <= '0;
            st_q      <= '0;
            lost_q    <= 1'b0;
        end else begin
            unique case (state_q)
                DECODE: begin
                    spec_st_q <= spec_st_d;
                    lost_q    <= 1'b0;
                end
                ITER: lost_q <= lost_q | (|lost_c);
                NORM: begin
                    st_q <= spec_q ? spec_st_q
                          : {2'b00, ~nrm[LW-1],
                             guard | sticky | lost_q | (|(f_q & SURP_MASK))};
                end
                default: ;
            endcase
        end
    end

    assign status = st_q;
`else
    logic unused_lost;
    assign unused_lost = ^{lost_c, f_q};
`endif

endmodule

// File: tb/tb_fp_log2_seq.sv
// Directed bench for fp_log2_seq at 1, 2 and 4 iterations per cycle.
module tb_fp_log2_seq;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] g_input = '0;
    logic [W-1:0] e_input = '0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;

    logic in_ready1, in_ready2, in_ready4;
    logic out_valid1, out_valid2, out_valid4;
    logic [W-1:0] o1, o2, o4;
`ifdef FP_LOG2_SEQ_STATUS_EN
    logic [3:0] st1, st2, st4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_log2_seq #(.SIG_WIDTH(23), .EXP_WIDTH(8), .EXTRA_PREC(0),
                  .ITER_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .g_input(g_input), .e_input(e_input),
        .in_valid(in_valid), .in_ready(in_ready1), .o(o1),
        .out_valid(out_valid1), .out_ready(out_ready)
`ifdef FP_LOG2_SEQ_STATUS_EN
        , .status(st1)
`endif
    );

    fp_log2_seq #(.SIG_WIDTH(23), .EXP_WIDTH(8), .EXTRA_PREC(0),
                  .ITER_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .g_input(g_input), .e_input(e_input),
        .in_valid(in_valid), .in_ready(in_ready2), .o(o2),
        .out_valid(out_valid2), .out_ready(out_ready)
`ifdef FP_LOG2_SEQ_STATUS_EN
        , .status(st2)
`endif
    );

    fp_log2_seq #(.SIG_WIDTH(23), .EXP_WIDTH(8), .EXTRA_PREC(0),
                  .ITER_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .g_input(g_input), .e_input(e_input),
        .in_valid(in_valid), .in_ready(in_ready4), .o(o4),
        .out_valid(out_valid4), .out_ready(out_ready)
`ifdef FP_LOG2_SEQ_STATUS_EN
        , .status(st4)
`endif
    );

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, req);
        end
    endtask

    task automatic apply(input logic [W-1:0] a);
        logic [W-1:0] r;
        r = $urandom;
        @(negedge clk);
        g_input  = a ^ r;
        e_input  = r;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag, input logic [W-1:0] req_o,
                            input int l1e, input int l2e, input int l4e,
                            input logic [3:0] req_st);
        int l1 = -1;
        int l2 = -1;
        int l4 = -1;
        for (int n = 1; n <= 120; n++) begin
            @(posedge clk);
            #1;
            if (l1 < 0 && out_valid1) l1 = n;
            if (l2 < 0 && out_valid2) l2 = n;
            if (l4 < 0 && out_valid4) l4 = n;
            if (l1 >= 0 && l2 >= 0 && l4 >= 0) break;
        end
        check({tag, "_lat1"}, 64'(l1), 64'(l1e));
        check({tag, "_lat2"}, 64'(l2), 64'(l2e));
        check({tag, "_lat4"}, 64'(l4), 64'(l4e));
        check({tag, "_o1"}, 64'(o1), 64'(req_o));
        check({tag, "_o2"}, 64'(o2), 64'(req_o));
        check({tag, "_o4"}, 64'(o4), 64'(req_o));
`ifdef FP_LOG2_SEQ_STATUS_EN
        check({tag, "_st"}, 64'({st1, st2, st4}), 64'({3{req_st}}));
`else
        if (req_st === 4'hx) $display("status tag %s", tag);
`endif
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_drop"},
              64'({out_valid1, out_valid2, out_valid4,
                   in_ready1, in_ready2, in_ready4}),
              64'b000111);
    endtask

    task automatic run(input string tag, input logic [W-1:0] a,
                       input logic [W-1:0] req_o, input logic spec,
                       input logic [3:0] req_st);
        apply(a);
        if (spec) wait_res(tag, req_o, 2, 2, 2, req_st);
        else      wait_res(tag, req_o, 27, 15, 9, req_st);
        handshake(tag);
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        check("rst_ready", 64'({in_ready1, in_ready2, in_ready4}), 64'b111);
        check("rst_valid", 64'({out_valid1, out_valid2, out_valid4}), 64'b0);
        check("rst_o", 64'({o1, o2, o4}), 64'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run("one",    32'h3F800000, 32'h00000000, 1'b0, 4'b0010);
        run("eight",  32'h41000000, 32'h40400000, 1'b0, 4'b0000);
        run("half",   32'h3F000000, 32'hBF800000, 1'b0, 4'b0000);
        run("ten",    32'h41200000, 32'h40549A78, 1'b0, 4'b0001);
        run("two",    32'h40000000, 32'h3F800000, 1'b0, 4'b0000);
        run("qtr",    32'h3E800000, 32'hC0000000, 1'b0, 4'b0000);
        run("minnrm", 32'h00800000, 32'hC2FC0000, 1'b0, 4'b0000);
        run("maxpw",  32'h7F000000, 32'h42FE0000, 1'b0, 4'b0000);

        run("zero",   32'h00000000, 32'hFF800000, 1'b1, 4'b0100);
        run("negz",   32'h80000000, 32'hFF800000, 1'b1, 4'b0100);
        run("neg",    32'hC0000000, 32'h7FC00000, 1'b1, 4'b1000);
        run("pinf",   32'h7F800000, 32'h7F800000, 1'b1, 4'b0100);
        run("ninf",   32'hFF800000, 32'h7FC00000, 1'b1, 4'b1000);
        run("nan",    32'h7F800001, 32'h7FC00000, 1'b1, 4'b1000);

        // Backpressure: result must hold while a new operand waits.
        apply(32'h41000000);
        wait_res("bp", 32'h40400000, 27, 15, 9, 4'b0000);
        @(negedge clk);
        g_input  = 32'h40800000;
        e_input  = 32'h00000000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold",
                  64'({out_valid1, out_valid2, out_valid4,
                       in_ready1, in_ready2, in_ready4}),
                  64'b111000);
            check("bp_o", 64'({o1, o2, o4}),
                  64'({32'h40400000, 32'h40400000, 32'h40400000}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp_release",
              64'({out_valid1, out_valid2, out_valid4,
                   in_ready1, in_ready2, in_ready4}),
              64'b000111);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp_accept", 64'({in_ready1, in_ready2, in_ready4}), 64'b000);
        wait_res("bp_next", 32'h40000000, 27, 15, 9, 4'b0000);
        handshake("bp_next");

        // Abort mid-iteration, then confirm a clean result afterwards.
        apply(32'h41200000);
        repeat (11) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_ready", 64'({in_ready1, in_ready2, in_ready4}), 64'b111);
        check("abort_valid", 64'({out_valid1, out_valid2, out_valid4}), 64'b0);
        check("abort_o", 64'({o1, o2, o4}), 64'b0);
        @(negedge clk);
        rst = 1'b1;
        run("post_rst", 32'h41200000, 32'h40549A78, 1'b0, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
